// File: rtl/dsm_stereo_modulator.sv
// Stereo 2nd-order 1-bit sigma-delta modulator: pair-committed PCM capture, linear
// fs->OSR*fs interpolation and a saturating two-integrator loop per channel.

module dsm_chan #(
  parameter int DATA_W     = 24,
  parameter int ACC_W      = 30,
  parameter int OSR_LOG2   = 6,
  parameter int GAIN_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_commit,
  input  logic [DATA_W-1:0] i_new,
  input  logic              i_step,
  input  logic              i_mod_stb,
  input  logic              i_en,
  input  logic              i_idle_bit,
  output logic              o_bit,
  output logic              o_clamp
);
  localparam int AI_W = DATA_W + OSR_LOG2 + 1;
  localparam int S_W  = ACC_W + 2;
  localparam logic signed [S_W-1:0] FB   = S_W'(2**(DATA_W-1));
  localparam logic signed [S_W-1:0] NFB  = -FB;
  localparam logic signed [S_W-1:0] LIM  = S_W'(2**(ACC_W-1) - 1);
  localparam logic signed [S_W-1:0] NLIM = -LIM;

  logic signed [DATA_W-1:0] r_prev, r_tgt;
  logic signed [AI_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]  r_i1, r_i2;
  logic                     r_bit;

  logic signed [DATA_W:0]   w_delta;
  logic signed [AI_W-1:0]   w_acc_sh;
  logic signed [DATA_W-1:0] w_xi, w_xl;
  logic signed [S_W-1:0]    w_x, w_i1, w_i2, w_fb, w_s1, w_s2;
  logic signed [ACC_W-1:0]  w_n1, w_n2;
  logic                     w_y, w_c1, w_c2;
  logic                     w_unused;

  assign w_delta  = {r_tgt[DATA_W-1], r_tgt} - {r_prev[DATA_W-1], r_prev};
  assign w_acc_sh = r_acc >>> OSR_LOG2;
  assign w_xi     = w_acc_sh[DATA_W-1:0];
  assign w_xl     = w_xi >>> GAIN_SHIFT;
  assign w_x      = {{(S_W-DATA_W){w_xl[DATA_W-1]}}, w_xl};
  assign w_i1     = {{2{r_i1[ACC_W-1]}}, r_i1};
  assign w_i2     = {{2{r_i2[ACC_W-1]}}, r_i2};
  assign w_y      = ~r_i2[ACC_W-1];
  assign w_fb     = w_y ? FB : NFB;
  // Both integrators see the same feedback; i2 integrates the pre-update i1.
  assign w_s1     = w_i1 + w_x - w_fb;
  assign w_s2     = w_i2 + w_i1 - w_fb;
  assign w_unused = ^w_acc_sh[AI_W-1:DATA_W];

  always_comb begin
    w_n1 = w_s1[ACC_W-1:0];
    w_c1 = 1'b0;
    w_n2 = w_s2[ACC_W-1:0];
    w_c2 = 1'b0;
    if (w_s1 > LIM) begin
      w_n1 = LIM[ACC_W-1:0];
      w_c1 = 1'b1;
    end else if (w_s1 < NLIM) begin
      w_n1 = NLIM[ACC_W-1:0];
      w_c1 = 1'b1;
    end
    if (w_s2 > LIM) begin
      w_n2 = LIM[ACC_W-1:0];
      w_c2 = 1'b1;
    end else if (w_s2 < NLIM) begin
      w_n2 = NLIM[ACC_W-1:0];
      w_c2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_tgt  <= '0;
      r_acc  <= '0;
      r_i1   <= '0;
      r_i2   <= '0;
      r_bit  <= 1'b0;
    end else begin
      // Commit restarts the ramp from the previous target, exactly on grid.
      if (i_commit) begin
        r_prev <= r_tgt;
        r_tgt  <= i_new;
        r_acc  <= {r_tgt[DATA_W-1], r_tgt, {OSR_LOG2{1'b0}}};
      end else if (i_step) begin
        r_acc  <= r_acc + {{(AI_W-DATA_W-1){w_delta[DATA_W]}}, w_delta};
      end
      if (i_mod_stb) begin
        if (i_en) begin
          r_i1  <= w_n1;
          r_i2  <= w_n2;
          r_bit <= w_y;
        end else begin
          r_i1  <= '0;
          r_i2  <= '0;
          r_bit <= i_idle_bit;
        end
      end
    end
  end

  assign o_bit   = r_bit;
  assign o_clamp = i_mod_stb & i_en & (w_c1 | w_c2);
endmodule

module dsm_stereo_modulator #(
  parameter int IN_W       = 32,
  parameter int DATA_W     = 24,
  parameter int ACC_W      = 30,
  parameter int OSR_LOG2   = 6,
  parameter int GAIN_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] data_l_i,
  input  logic            data_l_stb_i,
  input  logic [IN_W-1:0] data_r_i,
  input  logic            data_r_stb_i,
  input  logic            mod_stb_i,
  input  logic            en_i,
  input  logic            ovl_clr_i,
  output logic [1:0]      dsm_out_o,
  output logic            overload_o
);
  logic [DATA_W-1:0]      r_pend_l;
  logic [OSR_LOG2:0]      r_n;
  logic                   r_idle_ph;
  logic                   r_ovl;
  logic [1:0][DATA_W-1:0] w_new;
  logic [1:0]             w_bit, w_clamp;
  logic                   w_step;
  logic                   w_unused;

  assign w_new[0] = data_l_stb_i ? data_l_i[IN_W-1 -: DATA_W] : r_pend_l;
  assign w_new[1] = data_r_i[IN_W-1 -: DATA_W];
  // A commit on a mod strobe takes priority; stepping resumes on the next strobe.
  assign w_step   = mod_stb_i & ~data_r_stb_i & ~r_n[OSR_LOG2];
  assign w_unused = ^{data_l_i[IN_W-DATA_W-1:0], data_r_i[IN_W-DATA_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_l  <= '0;
      r_n       <= '0;
      r_idle_ph <= 1'b0;
      r_ovl     <= 1'b0;
    end else begin
      if (data_l_stb_i) r_pend_l <= data_l_i[IN_W-1 -: DATA_W];
      if (data_r_stb_i)  r_n <= '0;
      else if (w_step)   r_n <= r_n + (OSR_LOG2+1)'(1);
      if (en_i)           r_idle_ph <= 1'b0;
      else if (mod_stb_i) r_idle_ph <= ~r_idle_ph;
      if (|w_clamp)       r_ovl <= 1'b1;
      else if (ovl_clr_i) r_ovl <= 1'b0;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_ch
    dsm_chan #(
      .DATA_W    (DATA_W),
      .ACC_W     (ACC_W),
      .OSR_LOG2  (OSR_LOG2),
      .GAIN_SHIFT(GAIN_SHIFT)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_commit  (data_r_stb_i),
      .i_new     (w_new[g]),
      .i_step    (w_step),
      .i_mod_stb (mod_stb_i),
      .i_en      (en_i),
      .i_idle_bit(~r_idle_ph),
      .o_bit     (w_bit[g]),
      .o_clamp   (w_clamp[g])
    );
  end

  assign dsm_out_o  = w_bit;
  assign overload_o = r_ovl;
endmodule

// File: tb/tb_dsm_stereo_modulator.sv
// Directed bench for dsm_stereo_modulator: exact start-up bit patterns, density windows
// derived from mean(y) = (1 + x/FB)/2, commit semantics, idle pattern and overload.

module tb_dsm_stereo_modulator;
  logic        clk = 1'b0;
  logic        rst, mod_stb, en, ovl_clr;
  logic [31:0] dl, dr, odl, odr;
  logic        sl, sr, osl, osr, oen;
  logic [1:0]  out, oout;
  logic        ovl, oovl;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dsm_stereo_modulator u_dut (
    .clk(clk), .rst(rst),
    .data_l_i(dl), .data_l_stb_i(sl), .data_r_i(dr), .data_r_stb_i(sr),
    .mod_stb_i(mod_stb), .en_i(en), .ovl_clr_i(ovl_clr),
    .dsm_out_o(out), .overload_o(ovl)
  );

  dsm_stereo_modulator #(.GAIN_SHIFT(0), .ACC_W(26)) u_ovl (
    .clk(clk), .rst(rst),
    .data_l_i(odl), .data_l_stb_i(osl), .data_r_i(odr), .data_r_stb_i(osr),
    .mod_stb_i(mod_stb), .en_i(oen), .ovl_clr_i(ovl_clr),
    .dsm_out_o(oout), .overload_o(oovl)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(output logic [1:0] b);
    mod_stb = 1'b1;
    tick();
    mod_stb = 1'b0;
    b = out;
    tick();
  endtask

  task automatic count(input int n, output int cl, output int cr);
    logic [1:0] b;
    cl = 0;
    cr = 0;
    for (int i = 0; i < n; i++) begin
      strobe(b);
      cl += int'(b[0]);
      cr += int'(b[1]);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    logic [1:0] b;
    int cl, cr;
    rst = 1'b1; mod_stb = 1'b1; en = 1'b1; ovl_clr = 1'b0;
    dl = '0; dr = '0; sl = 1'b0; sr = 1'b0;
    odl = '0; odr = '0; osl = 1'b0; osr = 1'b0; oen = 1'b1;
    repeat (3) tick();
    n_chk++; if (out !== 2'b00) begin n_fail++; $display("FAIL reset_out got %b want 00", out); end
    n_chk++; if (ovl !== 1'b0) begin n_fail++; $display("FAIL reset_ovl got %b want 0", ovl); end
    n_chk++; if (oovl !== 1'b0 || oout !== 2'b00) begin n_fail++; $display("FAIL reset_ovl_dut got %b/%b want 0/00", oovl, oout); end
    rst = 1'b0; mod_stb = 1'b0;
    tick();
    count(10, cl, cr);
    rst = 1'b1; mod_stb = 1'b1;
    repeat (3) tick();
    n_chk++; if (out !== 2'b00 || ovl !== 1'b0) begin n_fail++; $display("FAIL midrun_reset got %b/%b want 00/0", out, ovl); end
    rst = 1'b0; mod_stb = 1'b0;
    tick();
    strobe(b);
    n_chk++; if (b !== 2'b11) begin n_fail++; $display("FAIL first_after_reset got %b want 11", b); end
  endtask

  task automatic test_zero;
    logic [1:0] b;
    logic [1:0] exp_seq [4] = '{2'b11, 2'b00, 2'b00, 2'b11};
    int cl, cr;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(b);
      n_chk++; if (b !== exp_seq[i]) begin n_fail++; $display("FAIL zero_seq[%0d] got %b want %b", i, b, exp_seq[i]); end
    end
    count(1024, cl, cr);
    n_chk++; if (cl < 510 || cl > 514) begin n_fail++; $display("FAIL zero_dens_l got %0d want 512+/-2", cl); end
    n_chk++; if (cr < 510 || cr > 514) begin n_fail++; $display("FAIL zero_dens_r got %0d want 512+/-2", cr); end
    n_chk++; if (ovl !== 1'b0) begin n_fail++; $display("FAIL zero_ovl got %b want 0", ovl); end
  endtask

  task automatic test_dc;
    int cl, cr;
    do_reset();
    dl = 32'h4000_0000; dr = 32'hC000_0000; sl = 1'b1; sr = 1'b1;
    tick();
    sl = 1'b0; sr = 1'b0;
    count(128, cl, cr);
    count(1024, cl, cr);
    n_chk++; if (cl < 636 || cl > 644) begin n_fail++; $display("FAIL dc_dens_l got %0d want 640+/-4", cl); end
    n_chk++; if (cr < 380 || cr > 388) begin n_fail++; $display("FAIL dc_dens_r got %0d want 384+/-4", cr); end
    n_chk++; if (ovl !== 1'b0) begin n_fail++; $display("FAIL dc_ovl got %b want 0", ovl); end
  endtask

  task automatic test_pair_commit;
    int cl, cr;
    do_reset();
    // Left-only strobe with a large value must not reach the loop.
    dl = 32'h7FFF_FFFF; sl = 1'b1;
    tick();
    sl = 1'b0;
    count(256, cl, cr);
    n_chk++; if (cl < 126 || cl > 130) begin n_fail++; $display("FAIL left_only_dens got %0d want 128+/-2", cl); end
    dl = 32'h4000_0000; sl = 1'b1;
    tick();
    sl = 1'b0;
    repeat (10) tick();
    dl = 32'h7FFF_FFFF; dr = 32'h0; sr = 1'b1;
    tick();
    sr = 1'b0;
    count(64, cl, cr);
    n_chk++; if (cl < 32 || cl > 40) begin n_fail++; $display("FAIL split_ramp_l got %0d want 36+/-4", cl); end
    n_chk++; if (cr < 30 || cr > 34) begin n_fail++; $display("FAIL split_ramp_r got %0d want 32+/-2", cr); end
    count(64, cl, cr);
    count(1024, cl, cr);
    n_chk++; if (cl < 636 || cl > 644) begin n_fail++; $display("FAIL split_dens_l got %0d want 640+/-4", cl); end
  endtask

  task automatic test_same_cycle;
    int cl, cr;
    do_reset();
    dl = 32'h4000_0000; dr = 32'h0; sl = 1'b1; sr = 1'b1;
    tick();
    sl = 1'b0; sr = 1'b0;
    count(64, cl, cr);
    n_chk++; if (cl < 32 || cl > 40) begin n_fail++; $display("FAIL same_ramp_l got %0d want 36+/-4", cl); end
    count(64, cl, cr);
    count(1024, cl, cr);
    n_chk++; if (cl < 636 || cl > 644) begin n_fail++; $display("FAIL same_dens_l got %0d want 640+/-4", cl); end
    n_chk++; if (cr < 510 || cr > 514) begin n_fail++; $display("FAIL same_dens_r got %0d want 512+/-2", cr); end
  endtask

  task automatic test_overload;
    int cl, cr;
    do_reset();
    n_chk++; if (oovl !== 1'b0) begin n_fail++; $display("FAIL ovl_init got %b want 0", oovl); end
    odl = 32'h7FFF_FFFF; odr = 32'h0; osl = 1'b1; osr = 1'b1;
    tick();
    osl = 1'b0; osr = 1'b0;
    count(4096, cl, cr);
    n_chk++; if (oovl !== 1'b1) begin n_fail++; $display("FAIL ovl_set got %b want 1", oovl); end
    repeat (20) tick();
    n_chk++; if (oovl !== 1'b1) begin n_fail++; $display("FAIL ovl_held got %b want 1", oovl); end
    ovl_clr = 1'b1;
    tick();
    ovl_clr = 1'b0;
    n_chk++; if (oovl !== 1'b0) begin n_fail++; $display("FAIL ovl_clr got %b want 0", oovl); end
    n_chk++; if (ovl !== 1'b0) begin n_fail++; $display("FAIL main_no_ovl got %b want 0", ovl); end
  endtask

  task automatic test_enable;
    logic [1:0] b;
    logic [1:0] idle_seq [4] = '{2'b11, 2'b00, 2'b11, 2'b00};
    logic [1:0] run_seq  [4] = '{2'b11, 2'b00, 2'b00, 2'b11};
    int cl, cr;
    do_reset();
    count(6, cl, cr);
    en = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      strobe(b);
      n_chk++; if (b !== idle_seq[i]) begin n_fail++; $display("FAIL idle_seq[%0d] got %b want %b", i, b, idle_seq[i]); end
    end
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      strobe(b);
      n_chk++; if (b !== run_seq[i]) begin n_fail++; $display("FAIL reen_seq[%0d] got %b want %b", i, b, run_seq[i]); end
    end
    count(256, cl, cr);
    n_chk++; if (cl < 126 || cl > 130) begin n_fail++; $display("FAIL reen_dens got %0d want 128+/-2", cl); end
    // Commit landing on a mod strobe.
    dl = 32'h4000_0000; dr = 32'hC000_0000; sl = 1'b1; sr = 1'b1; mod_stb = 1'b1;
    tick();
    sl = 1'b0; sr = 1'b0; mod_stb = 1'b0;
    tick();
    count(64, cl, cr);
    n_chk++; if (cl < 32 || cl > 40) begin n_fail++; $display("FAIL coinc_ramp_l got %0d want 36+/-4", cl); end
    n_chk++; if (cr < 24 || cr > 32) begin n_fail++; $display("FAIL coinc_ramp_r got %0d want 28+/-4", cr); end
    count(64, cl, cr);
    count(1024, cl, cr);
    n_chk++; if (cl < 636 || cl > 644) begin n_fail++; $display("FAIL coinc_dens_l got %0d want 640+/-4", cl); end
    n_chk++; if (cr < 380 || cr > 388) begin n_fail++; $display("FAIL coinc_dens_r got %0d want 384+/-4", cr); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_dc();
    test_pair_commit();
    test_same_cycle();
    test_overload();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
